led_display_arbiter: RTL
========================

# led_display_arbiter

Shares the 4-digit 7-segment display between two requesters, A and B. Each requester can be, for example, a debug value monitor and a user-facing counter.
- Arbitrates with round-robin priority and a minimum hold time, so the display never flickers between sources.
- Converts the owner's 16-bit hex value and dot mask into active-low segment codes.
- Drives the `i_display_D0..D3` inputs of `led_display_controller`, which handles multiplexing and the shift registers.

## Interface
Parameters:
- HOLD_CYCLES, default 25000000: minimum ownership time in i_clk cycles (1 s at 25 MHz). Must be ≥ 1.
- HOLD_WIDTH, default 25: counter width; must hold HOLD_CYCLES-1.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset: synchronous, active-low.
- i_req_a  in  1  requester A wants the display; level, held while ownership is desired.
- i_value_a  in  16  A's hex value; [3:0] maps to D0, [15:12] maps to D3.
- i_dots_a  in  4  A's decimal points; bit n = 1 lights the DP of Dn.
- o_gnt_a  out  1  A currently owns the display (registered).
- i_req_b, i_value_b, i_dots_b, o_gnt_b: same as for A.
- o_owner  out  2  00 = none, 01 = A, 10 = B (registered; 11 is never produced).
- o_display_D0..o_display_D3  out  8 each  segment code {a,b,c,d,e,f,g,DP}, 0 = segment on (common anode).

## Operation
- FSM states: IDLE, OWN_A, OWN_B. Illegal encodings go to IDLE on the next edge.
- Registers:
  - last flag: 0 = A was the last owner, 1 = B.
  - hold counter (HOLD_WIDTH bits).
  - latched value (16 bits) and latched dots (4 bits).
- IDLE transitions:
  - Only A requests: go to OWN_A.
  - Only B requests: go to OWN_B.
  - Both request: grant the one that is not `last`.
  - Neither requests: stay in IDLE.
- Grant actions:
  - Load the hold counter with HOLD_CYCLES-1.
  - Set `last` to the granted requester.
  - Latch that requester's value and dots.
- While in OWN_x:
  - The counter decrements each cycle while nonzero. expired = (counter == 0).
  - While i_req_x = 1: re-latch i_value_x and i_dots_x every cycle (live update).
  - While i_req_x = 0: the latches freeze (last value is held).
- OWN_x exit rules, evaluated only when expired:
  - Other requester requests: hand over directly to OWN_other in one edge. This reloads the counter, latches the other's data and updates `last`. Applies whether or not x still requests.
  - Other not requesting and i_req_x = 0: go to IDLE.
  - Other not requesting and i_req_x = 1: stay in OWN_x.
- Not expired: stay in OWN_x regardless of requests.
- Segment encoding (DP off, bit0 = 1), hex digit to code: 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 b:C1 C:63 d:85 E:61 F:71.
  - Dot bit set: clear bit0 (code & 8'hFE).
- In IDLE every o_display_Dn = 8'hFF (blank).

## Timing
- Reset, on any edge with i_reset_n = 0, including mid-ownership:
  - state = IDLE, `last` = 1 (so A wins the first tie), counter = 0, latches = 0.
  - o_gnt_a = o_gnt_b = 0, o_owner = 00, all o_display_Dn = 8'hFF.
- Latency: a request seen at edge k gives grant, o_owner and the new o_display at edge k+1.
- Live update: a value change on the owner at edge k appears on o_display at edge k+1.
- Encoding: o_display is registered, decoded from the next latched data; no extra cycle of latency.
- Ownership beginning at edge g lasts at least HOLD_CYCLES cycles. The earliest release or handover is edge g+HOLD_CYCLES.
- Handover edge:
  - The old grant falls and the new grant rises on the same edge; there is never a cycle with both grants high.
  - o_display switches directly to the new owner's data with no blank cycle.
- Release to IDLE: grant falls and display blanks on the same edge.
- HOLD_CYCLES = 1: expired is true from the first owned cycle. Min ownership is 1 cycle, which gives strict alternation under constant contention.
- Simultaneous request rise from IDLE: the tie goes to non-`last`.
- Owner drops and re-raises its request before expiry: ownership is continuous; the counter is not reloaded.

## Test plan
All scenarios use HOLD_CYCLES = 4.
1. Reset, then i_req_a = 1, value 16'h1234, dots 0 → next edge: o_gnt_a = 1, o_owner = 01, D0 = 99, D1 = 0D, D2 = 25, D3 = 9F. Dots = 4'b0001 → D0 = 98.
2. A owns with value 16'hABCD. At the grant edge + 1, raise i_req_b and hold both → A keeps ownership for exactly 4 cycles, then on one edge o_gnt_a falls and o_gnt_b rises. B retains ownership for ≥ 4 cycles, then hands back to A.
3. Both requests rise together after reset → A is granted. Drop both, then raise both again → B is granted (round-robin).
4. A is granted value 16'h0F00, drops its request after 1 cycle, and its value changes to 16'hFFFF → display stays 03/03/71/03 (D0..D3) until expiry, then IDLE with all Dn = FF.
5. i_reset_n = 0 for 1 cycle during B ownership → next edge: both grants 0, o_owner = 00, all Dn = FF. If i_req_b is still high, B is re-granted 1 cycle after reset is released.
6. Single requester with constant request and no contention → ownership held indefinitely; live value updates are tracked with 1-cycle latency.

Source files
------------

// File: rtl/led_display_arbiter.sv
// Two-requester arbiter for the shared 4-digit 7-segment display: round-robin
// priority with a minimum hold time, plus hex-to-segment encoding of the owner's data.
module led_display_arbiter #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int HOLD_WIDTH  = 25
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_a,
    input  logic [15:0] i_value_a,
    input  logic [3:0]  i_dots_a,
    output logic        o_gnt_a,
    input  logic        i_req_b,
    input  logic [15:0] i_value_b,
    input  logic [3:0]  i_dots_b,
    output logic        o_gnt_b,
    output logic [1:0]  o_owner,
    output logic [7:0]  o_display_D0,
    output logic [7:0]  o_display_D1,
    output logic [7:0]  o_display_D2,
    output logic [7:0]  o_display_D3
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last;
    logic                  w_last_next;
    logic [HOLD_WIDTH-1:0] r_cnt;
    logic [HOLD_WIDTH-1:0] w_cnt_next;
    logic [15:0]           r_value;
    logic [15:0]           w_value_next;
    logic [3:0]            r_dots;
    logic [3:0]            w_dots_next;
    logic                  w_expired;
    logic                  w_grant_a;
    logic                  w_grant_b;

    logic                  r_gnt_a;
    logic                  r_gnt_b;
    logic [1:0]            r_owner;
    logic [7:0]            r_disp      [4];
    logic [7:0]            w_disp_next [4];

    // Common-anode codes {a,b,c,d,e,f,g,DP}; a set dot clears the DP bit.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic dot);
        logic [7:0] code;
        case (digit)
            4'h0: code = 8'h03;
            4'h1: code = 8'h9F;
            4'h2: code = 8'h25;
            4'h3: code = 8'h0D;
            4'h4: code = 8'h99;
            4'h5: code = 8'h49;
            4'h6: code = 8'h41;
            4'h7: code = 8'h1F;
            4'h8: code = 8'h01;
            4'h9: code = 8'h09;
            4'hA: code = 8'h11;
            4'hB: code = 8'hC1;
            4'hC: code = 8'h63;
            4'hD: code = 8'h85;
            4'hE: code = 8'h61;
            default: code = 8'h71;
        endcase
        return dot ? (code & 8'hFE) : code;
    endfunction

    assign w_expired = (r_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_value_next = r_value;
        w_dots_next  = r_dots;
        w_cnt_next   = w_expired ? r_cnt : (r_cnt - 1'b1);
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // On a tie, the requester that was not last served wins.
                if (i_req_a && (!i_req_b || r_last)) begin
                    w_grant_a = 1'b1;
                end else if (i_req_b) begin
                    w_grant_b = 1'b1;
                end
            end
            ST_OWN_A: begin
                if (w_expired && i_req_b) begin
                    w_grant_b = 1'b1;
                end else if (w_expired && !i_req_a) begin
                    w_state_next = ST_IDLE;
                end else if (i_req_a) begin
                    w_value_next = i_value_a;
                    w_dots_next  = i_dots_a;
                end
            end
            ST_OWN_B: begin
                if (w_expired && i_req_a) begin
                    w_grant_a = 1'b1;
                end else if (w_expired && !i_req_b) begin
                    w_state_next = ST_IDLE;
                end else if (i_req_b) begin
                    w_value_next = i_value_b;
                    w_dots_next  = i_dots_b;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_grant_a) begin
            w_state_next = ST_OWN_A;
            w_last_next  = 1'b0;
            w_cnt_next   = HOLD_LOAD;
            w_value_next = i_value_a;
            w_dots_next  = i_dots_a;
        end else if (w_grant_b) begin
            w_state_next = ST_OWN_B;
            w_last_next  = 1'b1;
            w_cnt_next   = HOLD_LOAD;
            w_value_next = i_value_b;
            w_dots_next  = i_dots_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_value <= '0;
            r_dots  <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
            r_value <= w_value_next;
            r_dots  <= w_dots_next;
        end
    end

    // Outputs are decoded from the next-state data so they land on the same edge as the grant.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign w_disp_next[gi] = (w_state_next == ST_IDLE) ? 8'hFF
                               : seg_encode(w_value_next[gi*4 +: 4], w_dots_next[gi]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_owner <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                r_disp[i] <= 8'hFF;
            end
        end else begin
            r_gnt_a <= (w_state_next == ST_OWN_A);
            r_gnt_b <= (w_state_next == ST_OWN_B);
            case (w_state_next)
                ST_OWN_A: r_owner <= 2'b01;
                ST_OWN_B: r_owner <= 2'b10;
                default:  r_owner <= 2'b00;
            endcase
            for (int i = 0; i < 4; i++) begin
                r_disp[i] <= w_disp_next[i];
            end
        end
    end

    assign o_gnt_a      = r_gnt_a;
    assign o_gnt_b      = r_gnt_b;
    assign o_owner      = r_owner;
    assign o_display_D0 = r_disp[0];
    assign o_display_D1 = r_disp[1];
    assign o_display_D2 = r_disp[2];
    assign o_display_D3 = r_disp[3];

endmodule
